// File: rtl/counter_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer_if
// Brief    : Command/status bundle between a controller and counter_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface counter_sequencer_if #(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_arg;
    logic [STEP_W-1:0] cmd_steps;
    logic              pause;
    logic              abort;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic [STEP_W-1:0] steps_left;
    logic              done;
    logic              wrap;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_steps, pause, abort,
        input  cmd_ready, count, busy, steps_left, done, wrap
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_steps, pause, abort,
        output cmd_ready, count, busy, steps_left, done, wrap
    );
endinterface
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : counter_sequencer
// Brief    : Command-driven up/down wrap-around counter with pause and abort.
// Revision : 1.0 - initial release
// ============================================================================
module counter_sequencer #(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    counter_sequencer_if.slave     bus
);

    localparam logic [1:0] c_OP_LOAD = 2'b00;
    localparam logic [1:0] c_OP_UP   = 2'b01;
    localparam logic [1:0] c_OP_DOWN = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            r_state,      w_state_nxt;
    logic [WIDTH-1:0]  r_count,      w_count_nxt;
    logic [STEP_W-1:0] r_steps_left, w_steps_left_nxt;
    logic              r_up,         w_up_nxt;
    logic              r_done,       w_done_nxt;
    logic              r_wrap,       w_wrap_nxt;

    logic [WIDTH-1:0]  w_count_step;
    logic              w_step_wraps;

    assign w_count_step = r_up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
    assign w_step_wraps = r_up ? (r_count == {WIDTH{1'b1}}) : (r_count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_steps_left <= '0;
            r_up         <= 1'b0;
            r_done       <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_steps_left <= w_steps_left_nxt;
            r_up         <= w_up_nxt;
            r_done       <= w_done_nxt;
            r_wrap       <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_steps_left_nxt = r_steps_left;
        w_up_nxt         = r_up;
        w_done_nxt       = 1'b0;
        w_wrap_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        c_OP_LOAD: begin
                            w_count_nxt = bus.cmd_arg;
                            w_done_nxt  = 1'b1;
                        end
                        c_OP_UP, c_OP_DOWN: begin
                            // A zero-length run completes immediately like a NOP.
                            if (bus.cmd_steps == '0) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_up_nxt         = (bus.cmd_op == c_OP_UP);
                                w_steps_left_nxt = bus.cmd_steps;
                                w_state_nxt      = ST_RUN;
                            end
                        end
                        default: w_done_nxt = 1'b1;
                    endcase
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_state_nxt      = ST_IDLE;
                    w_steps_left_nxt = '0;
                end else if (!bus.pause) begin
                    w_count_nxt      = w_count_step;
                    w_wrap_nxt       = w_step_wraps;
                    w_steps_left_nxt = r_steps_left - STEP_W'(1);
                    if (r_steps_left == STEP_W'(1)) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.count      = r_count;
    assign bus.steps_left = r_steps_left;
    assign bus.busy       = (r_state == ST_RUN);
    assign bus.cmd_ready  = (r_state == ST_IDLE);
    assign bus.done       = r_done;
    assign bus.wrap       = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_sequencer
// Brief    : Directed and randomized checks of counter_sequencer against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_sequencer;

    localparam int WIDTH  = 3;
    localparam int STEP_W = 8;
    localparam int MOD    = 1 << WIDTH;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    counter_sequencer_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus();

    counter_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: plain integers, one update per clock edge.
    int m_cnt, m_left, m_run, m_up, m_done, m_wrap;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_cnt = 0; m_left = 0; m_run = 0; m_up = 0; m_done = 0; m_wrap = 0;
    endfunction

    function automatic void model_step();
        int nxt;
        m_done = 0;
        m_wrap = 0;
        if (!m_run) begin
            if (bus.cmd_valid) begin
                case (int'(bus.cmd_op))
                    0: begin m_cnt = int'(bus.cmd_arg); m_done = 1; end
                    1, 2: begin
                        if (bus.cmd_steps == 0) m_done = 1;
                        else begin
                            m_run  = 1;
                            m_left = int'(bus.cmd_steps);
                            m_up   = (bus.cmd_op == 2'd1) ? 1 : 0;
                        end
                    end
                    default: m_done = 1;
                endcase
            end
        end else if (bus.abort) begin
            m_run  = 0;
            m_left = 0;
        end else if (!bus.pause) begin
            nxt    = m_cnt + (m_up ? 1 : -1);
            m_wrap = (nxt < 0 || nxt >= MOD) ? 1 : 0;
            m_cnt  = (nxt + MOD) % MOD;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_run  = 0;
                m_done = 1;
            end
        end
    endfunction

    task automatic check_all();
        chk("count",      int'(bus.count),      m_cnt);
        chk("busy",       int'(bus.busy),       m_run);
        chk("steps_left", int'(bus.steps_left), m_left);
        chk("done",       int'(bus.done),       m_done);
        chk("wrap",       int'(bus.wrap),       m_wrap);
        chk("cmd_ready",  int'(bus.cmd_ready),  m_run ? 0 : 1);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_cmd(input logic v, input logic [1:0] op,
                           input logic [WIDTH-1:0] arg, input logic [STEP_W-1:0] steps);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        bus.cmd_steps = steps;
    endtask

    initial begin
        int t;
        reset_n = 1'b0;
        set_cmd(1'b0, 2'd3, '0, '0);
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        model_reset();
        #1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_ready", int'(bus.cmd_ready), 1);
        chk("rst_busy",  int'(bus.busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // LOAD 5
        set_cmd(1'b1, 2'd0, 3'd5, '0);
        cycle();
        chk("load_count", int'(bus.count), 5);
        chk("load_done",  int'(bus.done), 1);
        set_cmd(1'b0, 2'd3, '0, '0);
        cycle();
        chk("load_done_off", int'(bus.done), 0);
        chk("load_busy",     int'(bus.busy), 0);

        // UP 3 from 6, wrapping on the second step
        set_cmd(1'b1, 2'd0, 3'd6, '0);
        cycle();
        set_cmd(1'b1, 2'd1, '0, 8'd3);
        cycle();
        chk("up_left0", int'(bus.steps_left), 3);
        chk("up_ready0", int'(bus.cmd_ready), 0);
        set_cmd(1'b0, 2'd3, '0, '0);
        cycle();
        chk("up_e1_count", int'(bus.count), 7);
        chk("up_e1_wrap",  int'(bus.wrap), 0);
        cycle();
        chk("up_e2_count", int'(bus.count), 0);
        chk("up_e2_wrap",  int'(bus.wrap), 1);
        cycle();
        chk("up_e3_count", int'(bus.count), 1);
        chk("up_e3_done",  int'(bus.done), 1);
        chk("up_e3_wrap",  int'(bus.wrap), 0);

        // DOWN 4 from 2 with a two-cycle pause; a command offered while busy is ignored
        set_cmd(1'b1, 2'd0, 3'd2, '0);
        cycle();
        set_cmd(1'b1, 2'd2, '0, 8'd4);
        cycle();
        t = 1;
        set_cmd(1'b0, 2'd3, '0, '0);
        cycle(); t++;
        chk("dn_e1_count", int'(bus.count), 1);
        bus.pause = 1'b1;
        set_cmd(1'b1, 2'd0, 3'd5, '0);
        cycle(); t++;
        cycle(); t++;
        chk("dn_pause_count", int'(bus.count), 1);
        chk("dn_pause_left",  int'(bus.steps_left), 3);
        bus.pause = 1'b0;
        set_cmd(1'b0, 2'd3, '0, '0);
        while (!bus.done && t < 20) begin
            cycle(); t++;
        end
        chk("dn_cycles", t, 7);
        chk("dn_final_count", int'(bus.count), 6);

        // UP 10 aborted on the 4th run edge
        set_cmd(1'b1, 2'd1, '0, 8'd10);
        cycle();
        set_cmd(1'b0, 2'd3, '0, '0);
        repeat (3) cycle();
        bus.abort = 1'b1;
        cycle();
        chk("ab_count", int'(bus.count), 1);
        chk("ab_busy",  int'(bus.busy), 0);
        chk("ab_left",  int'(bus.steps_left), 0);
        chk("ab_done",  int'(bus.done), 0);
        bus.abort = 1'b0;
        set_cmd(1'b1, 2'd0, 3'd3, '0);
        cycle();
        chk("ab_load_count", int'(bus.count), 3);

        // Zero-step UP and NOP
        set_cmd(1'b1, 2'd1, '0, '0);
        cycle();
        chk("zs_done",  int'(bus.done), 1);
        chk("zs_count", int'(bus.count), 3);
        set_cmd(1'b1, 2'd3, 3'd7, 8'd9);
        cycle();
        chk("nop_done",  int'(bus.done), 1);
        chk("nop_busy",  int'(bus.busy), 0);
        chk("nop_count", int'(bus.count), 3);

        // Asynchronous reset in the middle of a run
        set_cmd(1'b1, 2'd1, '0, 8'd20);
        cycle();
        set_cmd(1'b0, 2'd3, '0, '0);
        repeat (3) cycle();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("ar_count", int'(bus.count), 0);
        chk("ar_busy",  int'(bus.busy), 0);
        chk("ar_left",  int'(bus.steps_left), 0);
        chk("ar_ready", int'(bus.cmd_ready), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        set_cmd(1'b1, 2'd0, 3'd2, '0);
        cycle();
        chk("ar_load_count", int'(bus.count), 2);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            set_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    WIDTH'($urandom), ($urandom_range(0, 7) == 0) ?
                    STEP_W'($urandom_range(0, 40)) : STEP_W'($urandom_range(0, 5)));
            bus.pause = ($urandom_range(0, 4) == 0);
            bus.abort = ($urandom_range(0, 15) == 0);
            cycle();
        end

        set_cmd(1'b0, 2'd3, '0, '0);
        bus.pause = 1'b0;
        bus.abort = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
